// File: rtl/lcd_text_streamer.sv
// lcd_text_streamer: HD44780 power-up sequence, then two-line frames as a valid/ready byte stream.
module lcd_text_streamer #(
  parameter logic [31:0] CLEAR_WAIT = 32'd100_000,
  parameter logic [7:0]  LINE1_ADDR = 8'h80,
  parameter logic [7:0]  LINE2_ADDR = 8'hC0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] line1_text,
  input  logic [127:0] line2_text,
  input  logic         message_updated,
  input  logic         lcd_ready,
  output logic         lcd_valid,
  output logic         lcd_rs,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         busy,
  output logic         frame_done
);
  typedef enum logic [2:0] {INIT_CMD, INIT_WAIT, IDLE, ADDR1, DATA1, ADDR2, DATA2, DONE} state_t;
  state_t state, state_n;
  logic [3:0] index, index_n;
  logic [31:0] cnt;
  logic pending, gap, sending, xfer, go, latch;
  logic [127:0] shadow1, shadow2;
  logic [7:0] init_byte, byte_sel;
  assign sending = state inside {INIT_CMD, ADDR1, DATA1, ADDR2, DATA2};
  // gap forces valid low for one cycle after every accepted byte
  assign lcd_valid = sending && !gap;
  assign xfer = lcd_valid && lcd_ready;
  assign go = pending || message_updated;
  assign latch = state_n == ADDR1 && state != ADDR1;
  assign init_byte = index[1:0] == 2'd0 ? 8'h38 :
                     index[1:0] == 2'd1 ? 8'h0C :
                     index[1:0] == 2'd2 ? 8'h01 : 8'h06;
  assign byte_sel = state == INIT_CMD ? init_byte :
                    state == ADDR1 ? LINE1_ADDR :
                    state == ADDR2 ? LINE2_ADDR :
                    state == DATA1 ? shadow1[{~index, 3'b000} +: 8] :
                    shadow2[{~index, 3'b000} +: 8];
  assign lcd_rs = lcd_valid && (state == DATA1 || state == DATA2);
  assign lcd_data = lcd_valid ? byte_sel : 8'h00;
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  always_comb begin
    state_n = state;
    index_n = index;
    case (state)
      INIT_CMD: if (xfer) begin
        index_n = index + 4'd1;
        if (index == 4'd2) state_n = INIT_WAIT;
        else if (index == 4'd3) begin
          index_n = 4'd0;
          state_n = go ? ADDR1 : IDLE;
        end
      end
      INIT_WAIT: state_n = cnt == CLEAR_WAIT - 32'd1 ? INIT_CMD : INIT_WAIT;
      IDLE:      state_n = go ? ADDR1 : IDLE;
      ADDR1:     state_n = xfer ? DATA1 : ADDR1;
      DATA1: if (xfer) begin
        index_n = index + 4'd1;
        state_n = index == 4'd15 ? ADDR2 : DATA1;
      end
      ADDR2:     state_n = xfer ? DATA2 : ADDR2;
      DATA2: if (xfer) begin
        index_n = index + 4'd1;
        state_n = index == 4'd15 ? DONE : DATA2;
      end
      DONE:      state_n = go ? ADDR1 : IDLE;
      default:   state_n = INIT_CMD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_CMD;
      index <= 4'd0;
      cnt <= 32'd0;
      pending <= 1'b0;
      gap <= 1'b1;
      init_done <= 1'b0;
    end else begin
      state <= state_n;
      index <= index_n;
      cnt <= state == INIT_WAIT ? cnt + 32'd1 : 32'd0;
      gap <= xfer;
      pending <= latch ? 1'b0 : (message_updated && state != IDLE) ? 1'b1 : pending;
      init_done <= init_done || (state == INIT_CMD && xfer && index == 4'd3);
    end
  end
  always_ff @(posedge clk) begin
    if (latch) begin
      shadow1 <= line1_text;
      shadow2 <= line2_text;
    end
  end
endmodule

// File: tb/tb_lcd_text_streamer.sv
// tb_lcd_text_streamer: randomized scoreboard bench; expected byte stream built from frame rules.
module tb_lcd_text_streamer;
  localparam logic [31:0] CW = 32'd200;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] line1_text = '0, line2_text = '0;
  logic message_updated = 1'b0;
  logic lcd_ready = 1'b1;
  logic lcd_valid, lcd_rs, init_done, busy, frame_done;
  logic [7:0] lcd_data;
  logic rand_ready = 1'b0;
  logic [8:0] exp_q[$];
  int errors = 0, checks = 0, n_xfer = 0, fd_cnt = 0, wcnt = 0;
  bit hold = 0, counting = 0;
  logic [8:0] hold_b;

  lcd_text_streamer #(.CLEAR_WAIT(CW)) dut (
    .clk(clk), .rst(rst), .line1_text(line1_text), .line2_text(line2_text),
    .message_updated(message_updated), .lcd_ready(lcd_ready), .lcd_valid(lcd_valid),
    .lcd_rs(lcd_rs), .lcd_data(lcd_data), .init_done(init_done), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input string s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  task automatic push_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic push_frame(input logic [127:0] l1, input logic [127:0] l2);
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[127 - 8*i -: 8]});
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[127 - 8*i -: 8]});
  endtask

  task automatic pulse();
    @(posedge clk); #1 message_updated = 1'b1;
    @(posedge clk); #1 message_updated = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    do begin @(negedge clk); #1; k++; end while ((busy || exp_q.size() != 0) && k < budget);
    chk({nm, " idle"}, {31'd0, busy}, 32'd0);
    chk({nm, " queue empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_xfer(input int target, input string nm);
    int k = 0;
    while (n_xfer < target && k < 2000) begin @(negedge clk); #1; k++; end
    chk({nm, " xfer reached"}, {31'd0, n_xfer >= target}, 32'd1);
  endtask

  initial forever begin
    @(posedge clk); #1;
    lcd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: pops the scoreboard on every accepted byte and checks handshake stability
  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
      counting = 0;
    end else begin
      if (hold) chk("stable while stalled", {23'd0, lcd_valid, lcd_rs, lcd_data}, {23'd0, 1'b1, hold_b});
      if (counting) begin
        if (lcd_valid) begin
          chk("clear wait cycles", wcnt, CW);
          counting = 0;
        end else wcnt++;
      end
      if (lcd_valid && lcd_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected byte: got %0h expected none", {lcd_rs, lcd_data});
        end else chk("byte", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_q.pop_front()});
        if ({lcd_rs, lcd_data} == 9'h001) begin
          counting = 1;
          wcnt = 0;
        end
      end
      hold = lcd_valid && !lcd_ready;
      hold_b = {lcd_rs, lcd_data};
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    int base, fd0, idle_seen;
    logic [127:0] r1, r2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset lcd_valid", {31'd0, lcd_valid}, 32'd0);
    chk("reset lcd_rs", {31'd0, lcd_rs}, 32'd0);
    chk("reset lcd_data", {24'd0, lcd_data}, 32'd0);
    chk("reset init_done", {31'd0, init_done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd1);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    push_init();
    @(posedge clk); #1 rst = 1'b0;
    wait_idle(CW + 200, "init");
    chk("init_done set", {31'd0, init_done}, 32'd1);

    line1_text = pack("E01: No Water");
    line2_text = pack("Check Pressure!");
    base = n_xfer; fd0 = fd_cnt;
    push_frame(line1_text, line2_text);
    pulse();
    wait_idle(500, "frame1");
    chk("frame1 transfers", n_xfer - base, 32'd34);
    chk("frame1 frame_done", fd_cnt - fd0, 32'd1);

    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r1[127 - 8*i -: 8] = 8'($urandom_range(32, 126));
      r2[127 - 8*i -: 8] = 8'($urandom_range(32, 126));
    end
    line1_text = r1; line2_text = r2;
    base = n_xfer; fd0 = fd_cnt;
    push_frame(r1, r2);
    pulse();
    line1_text = '0; line2_text = '0;
    wait_idle(2000, "random stall frame");
    chk("stall frame transfers", n_xfer - base, 32'd34);
    chk("stall frame frame_done", fd_cnt - fd0, 32'd1);

    line1_text = pack("E02: Jam");
    line2_text = pack("Open Door 2");
    base = n_xfer; fd0 = fd_cnt;
    push_frame(line1_text, line2_text);
    pulse();
    wait_xfer(base + 5, "pulse2");
    pulse();
    wait_xfer(base + 20, "pulse3");
    line1_text = pack("W01: Paper Low");
    line2_text = pack("Refill Tray");
    push_frame(line1_text, line2_text);
    pulse();
    wait_idle(4000, "collapsed pulses");
    repeat (50) @(negedge clk);
    chk("no third frame busy", {31'd0, busy}, 32'd0);
    chk("collapsed frames", fd_cnt - fd0, 32'd2);
    chk("collapsed transfers", n_xfer - base, 32'd68);

    rand_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    push_init();
    @(posedge clk); #1 rst = 1'b0;
    idle_seen = 0; fd0 = fd_cnt;
    repeat (20) @(negedge clk);
    line1_text = pack("E03: Low Ink");
    line2_text = pack("Replace Cart");
    push_frame(line1_text, line2_text);
    pulse();
    for (int k = 0; k < 2000 && fd_cnt == fd0; k++) begin
      @(negedge clk); #1;
      if (!busy) idle_seen++;
    end
    chk("init-wait pulse frame_done", fd_cnt - fd0, 32'd1);
    chk("no idle before frame", idle_seen, 32'd0);
    wait_idle(200, "init-wait frame");

    line1_text = pack("E04: Overheat");
    line2_text = pack("Cooling Down");
    base = n_xfer; fd0 = fd_cnt;
    push_frame(line1_text, line2_text);
    pulse();
    wait_xfer(base + 11, "abort point");
    rst = 1'b1;
    exp_q.delete();
    push_init();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    wait_idle(CW + 200, "re-init");
    chk("aborted frame no frame_done", fd_cnt - fd0, 32'd0);
    chk("re-init init_done", {31'd0, init_done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcd_text_streamer.md
Name: lcd_text_streamer

Overview:
- Sits directly downstream of the error/status message cycler; consumes two 16-character line buffers and their change pulse.
- Runs the HD44780 power-up command sequence, then writes each new frame to the LCD byte driver as a byte stream: line-1 address command, 16 data bytes, line-2 address command, 16 data bytes.
- Uses a valid/ready handshake toward the byte driver. The byte driver owns E-pulse and bus timing.

Parameters:
- CLEAR_WAIT, 32'd100_000, idle cycles after the clear-display command (2 ms at 50 MHz).
- LINE1_ADDR, 8'h80, set-DDRAM command for line 1.
- LINE2_ADDR, 8'hC0, set-DDRAM command for line 2.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; synchronous, active-high
- line1_text  in  128  line-1 characters; char 0 in [127:120]
- line2_text  in  128  line-2 characters, same packing
- message_updated  in  1  one-cycle pulse: line text changed
- lcd_ready  in  1  byte driver can accept a byte
- lcd_valid  out  1  byte presented to the driver
- lcd_rs  out  1  0 = command, 1 = data
- lcd_data  out  8  byte value
- init_done  out  1  init sequence complete (sticky until reset)
- busy  out  1  init or frame transfer in progress
- frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted

Behaviour:
- Reset (rst high at a clk edge) values: lcd_valid=0, lcd_rs=0, lcd_data=8'h00, init_done=0, busy=1, frame_done=0, pending=0, state=INIT_CMD, index=0.
- Reset asserted mid-operation aborts immediately; the next byte after release is the first init command.
- Handshake:
  - A transfer occurs on a cycle with lcd_valid && lcd_ready.
  - While lcd_valid=1 and no transfer has occurred, lcd_rs and lcd_data must stay stable.
  - lcd_valid never drops without a transfer.
  - The next byte may be presented on the cycle after a transfer. Peak rate is one byte per 2 cycles (the valid-low gap cycle is allowed).
- States:
  - INIT_CMD:
    - Sends 8'h38, 8'h0C, 8'h01, 8'h06 (rs=0), in that order.
    - After 8'h01 is accepted, go to INIT_WAIT.
    - After 8'h06 is accepted, set init_done=1 and go to IDLE, or to ADDR1 if pending.
  - INIT_WAIT: count CLEAR_WAIT cycles with lcd_valid=0, then return to INIT_CMD for 8'h06.
  - IDLE: busy=0. On message_updated=1 or pending=1, go to ADDR1.
  - Frame latch: line1_text/line2_text are latched into internal shadow registers in the same cycle the IDLE→ADDR1 transition is taken (and likewise for INIT_CMD→ADDR1 and DONE→ADDR1). Pending is cleared in that same cycle.
  - ADDR1: send LINE1_ADDR, rs=0.
  - DATA1: send shadow line 1, chars 0..15 in order, rs=1.
  - ADDR2: send LINE2_ADDR, rs=0.
  - DATA2: send shadow line 2, chars 0..15, rs=1.
  - DONE: one cycle. frame_done=1. Go to ADDR1 if pending, else IDLE.
- A frame is exactly 34 transfers. Character index is 4 bits; it wraps 15→0 on the line transition only.
- message_updated during init or during a frame (any state except IDLE):
  - Sets pending; multiple pulses collapse into one.
  - The in-flight frame is never altered; the shadow copy is used.
- message_updated in the DONE cycle sets pending, so a new frame follows immediately.
- message_updated in IDLE is consumed directly; pending stays 0.
- lcd_ready held low stalls indefinitely, with no timeout. Outputs are held.
- busy = 1 in every state except IDLE.

Test Plan:
- Reset release, lcd_ready=1 constantly → bytes 38,0C,01 (rs=0); then exactly 100_000 cycles with lcd_valid=0; then 06; then init_done=1, busy=0.
- After init, line1="E01: No Water", line2="Check Pressure!", pulse message_updated → 34 transfers: 80, 45 30 31 3A 20 4E 6F 20 57 61 74 65 72 20 20 20 (rs=1), C0, then line-2 ASCII with trailing 20; frame_done pulses once.
- lcd_ready toggled by a random generator during a frame → byte sequence identical to the no-stall run; rs/data never change while valid=1 and ready=0.
- Three message_updated pulses during a frame, inputs changed to "W01: Paper Low" before the last pulse → the first frame completes with the old text, then exactly one further frame with "W01: Paper Low"; no third frame.
- message_updated pulsed during INIT_WAIT → init completes, then one frame starts directly with 80 and no IDLE cycle.
- rst asserted after the 10th data byte of a frame → next transfer after release is 38; no frame_done for the aborted frame.
